// File: rtl/mpadder_sequencer_if.sv
// Handshake and control bundle between the Montgomery controller, the
// mpadder_sequencer and the carry-save multi-precision adder.
interface mpadder_sequencer_if;
   logic       start;
   logic [1:0] op;
   logic       reduce_only;
   logic       sub_finished;
   logic       c_zero;
   logic       ready;
   logic       enable_c;
   logic       shift;
   logic       subtract;
   logic [3:0] seg_sel;
   logic       done;
   logic       error;
   logic       shift_bit;
   logic [2:0] passes;

   // Controller / adder side: issues commands, reports adder flags
   modport master (
      output start, op, reduce_only, sub_finished, c_zero,
      input  ready, enable_c, shift, subtract, seg_sel, done, error,
             shift_bit, passes
   );

   // Sequencer side
   modport slave (
      input  start, op, reduce_only, sub_finished, c_zero,
      output ready, enable_c, shift, subtract, seg_sel, done, error,
             shift_bit, passes
   );
endinterface

// File: rtl/mpadder_sequencer.sv
// Control FSM for the 514-bit carry-save multi-precision adder.
// Runs one command at a time (accumulate, shift, resolve, reduce,
// resolve-then-reduce) and walks the adder's segment select. Every output
// is a register loaded from the next-state values, so no input reaches an
// output combinationally.
module mpadder_sequencer #(
   parameter int         NUM_SEGS   = 5,
   parameter logic [3:0] SEG_IDLE   = 4'b1000,
   parameter int         MAX_PASSES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mpadder_sequencer_if.slave   bus
);

   localparam logic [3:0] LAST_SEG   = 4'(NUM_SEGS - 1);
   localparam logic [2:0] PASS_LIMIT = 3'(MAX_PASSES);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ACC  = 3'd1,
      SHF  = 3'd2,
      RES  = 3'd3,
      SUB  = 3'd4,
      WB   = 3'd5,
      DONE = 3'd6
   } state_t;

   state_t     state_reg,     state_next;
   logic [3:0] seg_reg,       seg_next;
   logic [2:0] passes_reg,    passes_next;
   logic       reduce_reg,    reduce_next;
   logic       shift_bit_reg, shift_bit_next;
   logic       error_set;

   logic       ready_reg,     ready_next;
   logic       enable_c_reg,  enable_c_next;
   logic       shift_reg,     shift_next;
   logic       subtract_reg,  subtract_next;
   logic [3:0] seg_sel_reg,   seg_sel_next;
   logic       done_reg,      done_next;
   logic       error_reg,     error_next;

   // State, counters and registered outputs; reset aborts any command
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         seg_reg       <= 4'd0;
         passes_reg    <= 3'd0;
         reduce_reg    <= 1'b0;
         shift_bit_reg <= 1'b0;
         ready_reg     <= 1'b1;
         enable_c_reg  <= 1'b0;
         shift_reg     <= 1'b0;
         subtract_reg  <= 1'b0;
         seg_sel_reg   <= SEG_IDLE;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         seg_reg       <= seg_next;
         passes_reg    <= passes_next;
         reduce_reg    <= reduce_next;
         shift_bit_reg <= shift_bit_next;
         ready_reg     <= ready_next;
         enable_c_reg  <= enable_c_next;
         shift_reg     <= shift_next;
         subtract_reg  <= subtract_next;
         seg_sel_reg   <= seg_sel_next;
         done_reg      <= done_next;
         error_reg     <= error_next;
      end
   end

   // Next-state, segment counter and pass counter
   always_comb begin
      state_next     = state_reg;
      seg_next       = seg_reg;
      passes_next    = passes_reg;
      reduce_next    = reduce_reg;
      shift_bit_next = shift_bit_reg;
      error_set      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               seg_next = 4'd0;
               case (bus.op)
                  2'b00: state_next = ACC;
                  2'b01: state_next = SHF;
                  2'b10: begin
                     state_next  = RES;
                     reduce_next = 1'b0;
                  end
                  default: begin
                     reduce_next = 1'b1;
                     if (bus.reduce_only) begin
                        state_next  = SUB;
                        passes_next = 3'd0;
                     end else begin
                        state_next  = RES;
                     end
                  end
               endcase
            end
         end
         ACC: state_next = DONE;
         SHF: begin
            shift_bit_next = bus.c_zero;
            state_next     = DONE;
         end
         RES: begin
            if (seg_reg == LAST_SEG) begin
               seg_next = 4'd0;
               if (reduce_reg) begin
                  state_next  = SUB;
                  passes_next = 3'd0;
               end else begin
                  state_next  = DONE;
               end
            end else begin
               seg_next = seg_reg + 4'd1;
            end
         end
         SUB: begin
            if (seg_reg == LAST_SEG) begin
               // sub_finished is only meaningful on the last segment
               passes_next = passes_reg + 3'd1;
               seg_next    = 4'd0;
               if (bus.sub_finished) begin
                  state_next = DONE;
               end else if (passes_next == PASS_LIMIT) begin
                  state_next = DONE;
                  error_set  = 1'b1;
               end else begin
                  state_next = WB;
               end
            end else begin
               seg_next = seg_reg + 4'd1;
            end
         end
         WB: begin
            state_next = SUB;
            seg_next   = 4'd0;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode from the next state, loaded into the output registers
   always_comb begin
      ready_next    = (state_next == IDLE);
      enable_c_next = (state_next == ACC);
      shift_next    = (state_next == SHF);
      subtract_next = (state_next == SUB) || (state_next == WB);
      seg_sel_next  = ((state_next == RES) || (state_next == SUB)) ? seg_next : SEG_IDLE;
      done_next     = (state_next == DONE);
      error_next    = error_set;
   end

   assign bus.ready     = ready_reg;
   assign bus.enable_c  = enable_c_reg;
   assign bus.shift     = shift_reg;
   assign bus.subtract  = subtract_reg;
   assign bus.seg_sel   = seg_sel_reg;
   assign bus.done      = done_reg;
   assign bus.error     = error_reg;
   assign bus.shift_bit = shift_bit_reg;
   assign bus.passes    = passes_reg;

endmodule

// File: tb/tb_mpadder_sequencer.sv
// Self-checking bench for mpadder_sequencer: each command's expected
// per-cycle output trace is built from the command rules and compared
// cycle by cycle against the design.
module tb_mpadder_sequencer;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   mpadder_sequencer_if bus ();

   mpadder_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected trace: {ready, enable_c, shift, subtract, seg_sel, done, error}
   logic [9:0] exp_q[$];
   logic       sf_q[$];
   logic [2:0] exp_passes;
   logic       exp_shift_bit;

   localparam logic [9:0] IDLE_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};

   function automatic logic [9:0] vec(input logic en, input logic sh, input logic sb,
                                      input logic [3:0] seg, input logic dn, input logic er);
      return {1'b0, en, sh, sb, seg, dn, er};
   endfunction

   function automatic logic [9:0] observe();
      return {bus.ready, bus.enable_c, bus.shift, bus.subtract, bus.seg_sel, bus.done, bus.error};
   endfunction

   // Build the expected trace for one command; fin = pass on which the
   // adder reports sub_finished (values above 4 mean never)
   task automatic build(input logic [1:0] op_i, input logic ro, input int fin);
      int k;
      exp_q.delete();
      sf_q.delete();
      case (op_i)
         2'd0: begin exp_q.push_back(vec(1, 0, 0, 4'd8, 0, 0)); sf_q.push_back(1'($urandom_range(0, 1))); end
         2'd1: begin exp_q.push_back(vec(0, 1, 0, 4'd8, 0, 0)); sf_q.push_back(1'($urandom_range(0, 1))); end
         default: begin
            if (!(op_i == 2'd3 && ro)) begin
               for (int s = 0; s < 5; s++) begin
                  exp_q.push_back(vec(0, 0, 0, 4'(s), 0, 0));
                  sf_q.push_back(1'($urandom_range(0, 1)));
               end
            end
         end
      endcase
      if (op_i == 2'd3) begin
         k = (fin <= 4) ? fin : 4;
         for (int p = 1; p <= k; p++) begin
            for (int s = 0; s < 5; s++) begin
               exp_q.push_back(vec(0, 0, 1, 4'(s), 0, 0));
               if (s == 4) sf_q.push_back(p == fin);
               else        sf_q.push_back(1'($urandom_range(0, 1)));
            end
            if (p < k) begin
               exp_q.push_back(vec(0, 0, 1, 4'd8, 0, 0));
               sf_q.push_back(1'($urandom_range(0, 1)));
            end
         end
         exp_passes = 3'(k);
         exp_q.push_back(vec(0, 0, 0, 4'd8, 1, (fin > 4)));
      end else begin
         exp_q.push_back(vec(0, 0, 0, 4'd8, 1, 0));
      end
      sf_q.push_back(1'b0);
   endtask

   // Issue one command from IDLE and check every cycle through to IDLE.
   // cz_mode: 0/1 drive c_zero constant, 2 random. noise pulses start.
   task automatic run_cmd(input logic [1:0] op_i, input logic ro, input int fin,
                          input logic noise, input int cz_mode);
      logic [9:0] obs;
      logic       cz;
      int         cyc_bad;
      build(op_i, ro, fin);
      cyc_bad = 0;
      total++;
      if (bus.ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_before_start got=%b want=1", bus.ready);
      end
      bus.start       = 1'b1;
      bus.op          = op_i;
      bus.reduce_only = ro;
      bus.sub_finished = 1'b0;
      bus.c_zero      = 1'($urandom_range(0, 1));
      for (int t = 0; t < exp_q.size(); t++) begin
         @(negedge clk);
         obs = observe();
         total++;
         if (obs !== exp_q[t]) begin
            bad++;
            cyc_bad++;
            $display("FAIL trace op=%0d ro=%0d cyc=%0d got=%b want=%b", op_i, ro, t + 1, obs, exp_q[t]);
         end
         bus.start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.sub_finished = sf_q[t];
         cz = (cz_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(cz_mode);
         bus.c_zero = cz;
         if (t == 0 && op_i == 2'd1) exp_shift_bit = cz;
      end
      @(negedge clk);
      bus.start = 1'b0;
      obs = observe();
      total++;
      if (obs !== IDLE_VEC) begin
         bad++;
         $display("FAIL back_to_idle got=%b want=%b", obs, IDLE_VEC);
      end
      total++;
      if (bus.passes !== exp_passes) begin
         bad++;
         $display("FAIL passes got=%0d want=%0d", bus.passes, exp_passes);
      end
      total++;
      if (bus.shift_bit !== exp_shift_bit) begin
         bad++;
         $display("FAIL shift_bit got=%b want=%b", bus.shift_bit, exp_shift_bit);
      end
      $display("cmd op=%0d ro=%0d fin=%0d noise=%0d done_at=%0d cycle_errors=%0d",
               op_i, ro, fin, noise, exp_q.size(), cyc_bad);
   endtask

   task automatic test_reset();
      logic [9:0] obs;
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 2'd0; bus.reduce_only = 1'b0;
      bus.sub_finished = 1'b0; bus.c_zero = 1'b0;
      repeat (3) @(negedge clk);
      obs = observe();
      total++;
      if (obs !== IDLE_VEC || bus.passes !== 3'd0 || bus.shift_bit !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got=%b/%0d/%b want=%b/0/0", obs, bus.passes, bus.shift_bit, IDLE_VEC);
      end
      reset = 1'b0;
      @(negedge clk);
      obs = observe();
      total++;
      if (obs !== IDLE_VEC) begin
         bad++;
         $display("FAIL after_reset got=%b want=%b", obs, IDLE_VEC);
      end
      exp_passes = 3'd0;
      exp_shift_bit = 1'b0;
      $display("reset checked");
   endtask

   task automatic test_accum();
      run_cmd(2'd0, 1'b0, 9, 1'b0, 2);
   endtask

   task automatic test_shift();
      run_cmd(2'd1, 1'b0, 9, 1'b0, 1);
      run_cmd(2'd1, 1'b0, 9, 1'b0, 0);
   endtask

   task automatic test_resolve();
      run_cmd(2'd2, 1'b0, 9, 1'b1, 2);
   endtask

   task automatic test_resolve_reduce();
      run_cmd(2'd3, 1'b0, 2, 1'b0, 2);
   endtask

   task automatic test_reduce_fail();
      run_cmd(2'd3, 1'b1, 9, 1'b0, 2);
   endtask

   task automatic test_reset_mid();
      logic [9:0] obs;
      int         done_seen;
      bus.start = 1'b1; bus.op = 2'd3; bus.reduce_only = 1'b1; bus.sub_finished = 1'b0;
      repeat (3) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      obs = observe();
      total++;
      if (obs !== vec(0, 0, 1, 4'd2, 0, 0)) begin
         bad++;
         $display("FAIL mid_sub_seg2 got=%b want=%b", obs, vec(0, 0, 1, 4'd2, 0, 0));
      end
      reset = 1'b1;
      #1;
      obs = observe();
      total++;
      if (obs !== IDLE_VEC || bus.passes !== 3'd0 || bus.shift_bit !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got=%b/%0d/%b want=%b/0/0", obs, bus.passes, bus.shift_bit, IDLE_VEC);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_passes = 3'd0;
      exp_shift_bit = 1'b0;
      done_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.ready !== 1'b1) done_seen++;
      end
      total++;
      if (done_seen != 0) begin
         bad++;
         $display("FAIL post_reset_idle got=%0d busy_or_done_cycles want=0", done_seen);
      end
      $display("reset mid-command checked");
      run_cmd(2'd0, 1'b0, 9, 1'b0, 2);
   endtask

   // Back-to-back random commands, each launched the cycle ready returns
   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++) begin
         run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 5), 1'($urandom_range(0, 1)), 2);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_accum();
      test_shift();
      test_resolve();
      test_resolve_reduce();
      test_reduce_fail();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mpadder_sequencer.md
Name: mpadder_sequencer

Overview:
- Control FSM for the 514-bit carry-save multi-precision adder.
- Accepts one command at a time from the Montgomery top-level controller: accumulate, shift, carry-propagate resolve, conditional-subtract reduce, or resolve-then-reduce.
- Drives the adder's enable, shift, subtract and 4-bit segment-select lines, and reports completion with a one-cycle done pulse.
- Replaces ad-hoc segment counting in the top-level FSM.

Parameters:
- NUM_SEGS, 5, number of carry-propagate segments per pass; seg_sel walks 0..NUM_SEGS-1.
- SEG_IDLE, 4'b1000, seg_sel value outside a pass; bit3 set freezes the adder's inter-segment carry register.
- MAX_PASSES, 4, maximum subtract passes in a reduce before error is flagged.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only when ready=1.
- op  in  2  command: 00 ACCUM, 01 SHIFT, 10 RESOLVE, 11 RESOLVE_REDUCE.
- reduce_only  in  1  with op=11: skip the resolve phase, run reduce only.
- sub_finished  in  1  adder's subtract-finished flag; valid when seg_sel=NUM_SEGS-1 and subtract=1.
- c_zero  in  1  adder's carry-save LSB, used by SHIFT.
- ready  out  1  high in IDLE only.
- enable_c  out  1  carry-save register load strobe.
- shift  out  1  carry-save right-shift strobe.
- subtract  out  1  selects the subtract datapath.
- seg_sel  out  4  segment select to the adder.
- done  out  1  one-cycle completion pulse.
- error  out  1  with done: reduce hit MAX_PASSES without sub_finished.
- shift_bit  out  1  c_zero captured during the SHIFT action cycle; held until the next SHIFT.
- passes  out  3  subtract passes executed in the last reduce; held until the next reduce starts.

Behaviour:
- Reset values: state IDLE, ready=1, seg_sel=SEG_IDLE, all strobes 0, done=0, error=0, shift_bit=0, passes=0.
- All outputs are registered; no combinational path from an input to an output.
- Reset asserted mid-command aborts at once: state returns to IDLE, no done pulse, outputs return to reset values.
- States: IDLE, ACC, SHF, RES, SUB, WB, DONE.
- IDLE:
  - start=1 with op=00 -> ACC; op=01 -> SHF; op=10 -> RES.
  - op=11 -> RES, or SUB when reduce_only=1.
  - start while not in IDLE is ignored (not queued).
- ACC: one cycle with enable_c=1 -> DONE.
- SHF: one cycle with shift=1; shift_bit<=c_zero at the end of the cycle -> DONE.
- RES:
  - seg_sel = 0,1,..,NUM_SEGS-1 on consecutive cycles, subtract=0.
  - After the last segment: op=10 -> DONE; op=11 -> SUB with seg_sel restarting at 0 and passes cleared to 0.
- SUB:
  - seg_sel = 0..NUM_SEGS-1 with subtract=1.
  - At seg_sel=NUM_SEGS-1, sub_finished is sampled and passes increments.
  - If sub_finished=1 -> DONE, error=0.
  - Else if passes (after increment) = MAX_PASSES -> DONE with error=1.
  - Else -> WB.
- WB: one cycle, subtract=1, seg_sel=SEG_IDLE, commits the difference into the adder's B register -> SUB, seg 0.
- DONE: done=1 for exactly one cycle, strobes 0, seg_sel=SEG_IDLE -> IDLE; ready=1 the following cycle.
- seg_sel is SEG_IDLE in every state except RES and SUB.
- enable_c, shift and subtract are mutually exclusive; at most one is high in any cycle.
- Latency from the start edge to the done cycle:
  - ACCUM and SHIFT: 2 cycles.
  - RESOLVE: NUM_SEGS+1 = 6 cycles.
  - Reduce with k passes: k*NUM_SEGS + (k-1) WB cycles, plus 1 for DONE; added to the resolve time unless reduce_only=1.
- error is held low except in the DONE cycle that ends a failed reduce.

Test Plan:
- Reset then op=00 start -> enable_c high exactly 1 cycle, done 2 cycles after start; seg_sel stays 4'b1000 throughout.
- op=01 with c_zero=1 -> shift high 1 cycle, shift_bit=1 after done; repeat with c_zero=0 -> shift_bit=0.
- op=10 -> seg_sel sequence 0,1,2,3,4 with subtract=0, then done, 6 cycles after start; start pulsed mid-sequence is ignored.
- op=11, reduce_only=0, sub_finished=1 on the 2nd pass at seg 4 -> 5 resolve cycles, 5 SUB, 1 WB, 5 SUB, then done with passes=2, error=0.
- op=11, reduce_only=1, sub_finished held 0 -> 4 passes with 3 WB cycles, then done with error=1 and passes=4.
- Reset asserted during SUB at seg_sel=2 -> outputs return to reset values immediately, no done pulse; a new op=00 completes normally.
